frac_strober: RTL

Parametrised successor to `strober`: a fractional-rate strobe generator with multi-channel round-robin output. It paces sample strobes at any clock/sample ratio with an `FRAC`-bit fractional part, so 216 MHz → 48 kHz-class rates need no integer-exact divisor. The rate can be changed glitch-free at period boundaries. It sits in front of `transmitter`/`frame_monitor` in the `clk_216` domain, replacing `strober` + `edge_detector`.

---
 rtl/strobe_pkg.sv | 10 +
 rtl/rr_index.sv | 29 ++
 rtl/frac_strober.sv | 106 ++++++++++
 3 files changed

// File: rtl/strobe_pkg.sv
// Shared constants and width helpers for the strobe generator family.
package strobe_pkg;

   localparam int unsigned MIN_RATE = 2;

   function automatic int unsigned CHAN_W(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_index.sv
// Modulo-CHANNELS wrap counter with one-hot decode of the current index.
module rr_index
   import strobe_pkg::*;
#(
   parameter  int unsigned CHANNELS = 2,
   localparam int unsigned CW       = CHAN_W(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                advance,
   output logic [CW-1:0]       index,
   output logic [CHANNELS-1:0] onehot
);

   always_ff @(posedge clk) begin
      if (rst) begin
         index <= '0;
      end else if (advance) begin
         if (index == CW'(CHANNELS - 1)) index <= '0;
         else                            index <= index + CW'(1);
      end
   end

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) onehot[i] = (index == CW'(i));
   end

endmodule

// File: rtl/frac_strober.sv
// Fractional-rate strobe generator with glitch-free rate reload and
// round-robin distribution of strobes over CHANNELS outputs.
module frac_strober
   import strobe_pkg::*;
#(
   parameter int unsigned WIDTH     = 14,
   parameter int unsigned FRAC      = 8,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned INIT_INT  = 1000,
   parameter int unsigned INIT_FRAC = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [WIDTH-1:0]             rate_int,
   input  logic [FRAC-1:0]              rate_frac,
   input  logic                         rate_load,
   output logic                         rate_ack,
   output logic                         stb,
   output logic [CHANNELS-1:0]          stb_ch,
   output logic [CHAN_W(CHANNELS)-1:0]  chan
);

   localparam int unsigned CW = CHAN_W(CHANNELS);

   typedef struct packed {
      logic [WIDTH-1:0] ri;
      logic [FRAC-1:0]  rf;
   } rate_t;

   rate_t             active, shadow, req;
   logic              pending;
   logic              start;
   logic [FRAC-1:0]   acc;
   logic [FRAC:0]     sum;
   logic [WIDTH:0]    cnt, cnt_nxt, len, len_new;
   logic              hit;
   logic [CW-1:0]     idx;
   logic [CHANNELS-1:0] idx_oh;

   always_comb begin
      req.ri  = (rate_int < WIDTH'(MIN_RATE)) ? WIDTH'(MIN_RATE) : rate_int;
      req.rf  = rate_frac;
      sum     = {1'b0, acc} + {1'b0, active.rf};
      len_new = {1'b0, active.ri} + {{WIDTH{1'b0}}, sum[FRAC]};
      cnt_nxt = cnt + (WIDTH+1)'(1);
      // start marks the first enabled cycle of a period, where its length is fixed
      hit     = enable && !start && (cnt_nxt == len);
   end

   rr_index #(.CHANNELS(CHANNELS)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .advance (hit),
      .index   (idx),
      .onehot  (idx_oh)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         active   <= '{ri: WIDTH'(INIT_INT), rf: FRAC'(INIT_FRAC)};
         shadow   <= '0;
         pending  <= 1'b0;
         start    <= 1'b1;
         acc      <= '0;
         cnt      <= '0;
         len      <= '0;
         stb      <= 1'b0;
         stb_ch   <= '0;
         rate_ack <= 1'b0;
         chan     <= '0;
      end else begin
         stb      <= hit;
         stb_ch   <= hit ? idx_oh : '0;
         rate_ack <= hit && (rate_load || pending);
         if (hit) chan <= idx;

         if (enable) begin
            if (start) begin
               acc   <= sum[FRAC-1:0];
               len   <= len_new;
               cnt   <= (WIDTH+1)'(1);
               start <= 1'b0;
            end else if (hit) begin
               cnt   <= '0;
               start <= 1'b1;
            end else begin
               cnt   <= cnt_nxt;
            end
         end

         // A load coinciding with the strobe bypasses the shadow register
         if (hit && rate_load) begin
            active  <= req;
            pending <= 1'b0;
         end else if (hit && pending) begin
            active  <= shadow;
            pending <= 1'b0;
         end else if (rate_load) begin
            shadow  <= req;
            pending <= 1'b1;
         end
      end
   end

endmodule
